// File: rtl/ap_total_pkg.sv
// Shared types and defaults for the AP_total write interface and its collector.
// The mXv controller uses the same default widths and pipeline-fill count.
package ap_total_pkg;

  localparam int AP_ELEMENT_WIDTH = 32;
  localparam int AP_DEPTH         = 64;
  localparam int AP_PIPE_SKIP     = 2;
  localparam int AP_NO_OF_UNITS   = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2,
    DRAIN   = 2'd3
  } ap_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ap_total_ram.sv
// Simple dual-port buffer: one write port and one registered read port.
// The read register is reset so the replay data output starts from zero.
module ap_total_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read port; output holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_o <= {WIDTH{1'b0}};
    end else if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/ap_total_collector.sv
// Collects dot-product results from the mXv controller by row index, then
// replays the full vector in order on a valid/ready stream.
module ap_total_collector
  import ap_total_pkg::*;
#(
  parameter int element_width = AP_ELEMENT_WIDTH,
  parameter int no_of_units   = AP_NO_OF_UNITS,
  parameter int depth         = AP_DEPTH,
  parameter int addr_width    = clog2(AP_DEPTH),
  parameter int pipe_skip     = AP_PIPE_SKIP
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              total,
  input  logic                     AP_total_mem_we,
  input  logic [31:0]              counter2,
  input  logic [element_width-1:0] result,
  input  logic                     rd_start,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [element_width-1:0] rd_data,
  output logic [addr_width-1:0]    rd_index,
  output logic                     collect_done,
  output logic                     overflow_err,
  output logic [addr_width:0]      wr_count
);

  localparam int          CW         = addr_width + 1;
  localparam int          UNIT_SHIFT = clog2(no_of_units);
  localparam logic [31:0] SKIP32     = 32'(pipe_skip);
  localparam logic [31:0] DEPTH32    = 32'(depth);

  ap_state_e             state_q;
  logic [CW-1:0]         exp_q;
  logic [CW-1:0]         wr_count_q;
  logic [addr_width-1:0] rd_index_q;
  logic                  rd_valid_q;
  logic                  pend_q;
  logic                  collect_done_q;
  logic                  overflow_q;

  logic                  qual_s;
  logic [31:0]           addr_full_s;
  logic [31:0]           exp_new_s;
  logic [31:0]           exp_wide_s;
  logic                  exp_ok_s;
  logic                  hs_s;
  logic                  last_s;
  logic                  ram_we_s;
  logic                  ram_re_s;
  logic [addr_width-1:0] ram_raddr_s;

  // Strobe qualification, range checks and buffer port control.
  always_comb begin
    qual_s      = AP_total_mem_we && (counter2 >= SKIP32);
    addr_full_s = counter2 - SKIP32;
    exp_new_s   = total >> UNIT_SHIFT;
    exp_wide_s  = {{(32-CW){1'b0}}, exp_q};
    exp_ok_s    = (exp_new_s != 32'd0) && (exp_new_s <= DEPTH32);
    hs_s        = rd_valid_q && rd_ready;
    last_s      = ({1'b0, rd_index_q} == (exp_q - CW'(1'b1)));
    ram_we_s    = 1'b0;
    ram_re_s    = 1'b0;
    case (state_q)
      IDLE:    ram_we_s = qual_s && exp_ok_s && (addr_full_s < exp_new_s);
      COLLECT: ram_we_s = qual_s && (addr_full_s < exp_wide_s);
      FULL:    ram_re_s = rd_start;
      DRAIN:   ram_re_s = hs_s && !last_s;
      default: ram_re_s = 1'b0;
    endcase
    if (state_q == FULL) begin
      ram_raddr_s = {addr_width{1'b0}};
    end else begin
      ram_raddr_s = rd_index_q + addr_width'(1'b1);
    end
  end

  // Collect/replay FSM with its counters, flags and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      exp_q          <= {CW{1'b0}};
      wr_count_q     <= {CW{1'b0}};
      rd_index_q     <= {addr_width{1'b0}};
      rd_valid_q     <= 1'b0;
      pend_q         <= 1'b0;
      collect_done_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ram_we_s) begin
            exp_q      <= exp_new_s[addr_width:0];
            wr_count_q <= CW'(1'b1);
            if (exp_new_s == 32'd1) begin
              state_q        <= FULL;
              collect_done_q <= 1'b1;
            end else begin
              state_q <= COLLECT;
            end
          end else if (qual_s) begin
            overflow_q <= 1'b1;
          end
        end
        COLLECT: begin
          if (ram_we_s) begin
            wr_count_q <= wr_count_q + CW'(1'b1);
            if ((wr_count_q + CW'(1'b1)) == exp_q) begin
              state_q        <= FULL;
              collect_done_q <= 1'b1;
            end
          end else if (qual_s) begin
            overflow_q <= 1'b1;
          end
        end
        FULL: begin
          if (qual_s) overflow_q <= 1'b1;
          if (rd_start) begin
            state_q    <= DRAIN;
            rd_index_q <= {addr_width{1'b0}};
            pend_q     <= 1'b1;
          end
        end
        DRAIN: begin
          if (qual_s) overflow_q <= 1'b1;
          // pend_q marks the bubble while the registered read settles.
          if (pend_q) begin
            rd_valid_q <= 1'b1;
            pend_q     <= 1'b0;
          end else if (hs_s) begin
            rd_valid_q <= 1'b0;
            if (last_s) begin
              wr_count_q     <= {CW{1'b0}};
              collect_done_q <= 1'b0;
              state_q        <= IDLE;
            end else begin
              rd_index_q <= rd_index_q + addr_width'(1'b1);
              pend_q     <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  ap_total_ram #(
    .WIDTH (element_width),
    .DEPTH (depth),
    .AW    (addr_width)
  ) u_ram (
    .clk     (clk),
    .rst     (reset),
    .we_i    (ram_we_s),
    .waddr_i (addr_full_s[addr_width-1:0]),
    .wdata_i (result),
    .re_i    (ram_re_s),
    .raddr_i (ram_raddr_s),
    .rdata_o (rd_data)
  );

  assign rd_valid     = rd_valid_q;
  assign rd_index     = rd_index_q;
  assign collect_done = collect_done_q;
  assign overflow_err = overflow_q;
  assign wr_count     = wr_count_q;

endmodule
